// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared types and constants for the multi-cycle control sequencer
//   state_t         - sequencer state encoding (also driven on the State debug port)
//   OP_*            - instruction opcodes carried in IR[7:6]
//   ctrl_t          - bundle of datapath select/enable lines plus the retire pulse
//   COUNT_W_DEFAULT - default width of the retired-instruction counter
package cpu_ctrl_pkg;

    localparam int COUNT_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_J   = 2'b11;

    typedef struct packed {
        logic reg_dst;
        logic reg_write;
        logic alu_src;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
        logic iord;
        logic ir_write;
        logic pc_write;
        logic pc_src;
        logic instr_done;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational map from sequencer state, opcode and memory handshake to datapath controls
//   state     in   current sequencer state
//   op        in   opcode of the instruction in flight
//   mem_ready in   memory completes the current access this cycle
//   ctrl      out  control-line bundle; every line not raised for a state stays 0
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [1:0]  op,
    input  logic        mem_ready,
    output ctrl_t       ctrl
);

    logic fetch_go;
    logic jump;

    assign fetch_go = state == FETCH && mem_ready;
    assign jump     = state == DECODE && op == OP_J;

    always_comb begin
        ctrl            = '0;
        ctrl.mem_read   = state == FETCH || (state == MEM && op == OP_LW);
        ctrl.mem_write  = state == MEM && op == OP_SW;
        ctrl.iord       = state == MEM;
        ctrl.ir_write   = fetch_go;
        ctrl.pc_write   = fetch_go || jump;
        ctrl.pc_src     = jump;
        ctrl.alu_src    = state == EXEC && (op == OP_LW || op == OP_SW);
        ctrl.reg_write  = state == WB;
        ctrl.reg_dst    = state == WB && op == OP_ADD;
        ctrl.mem_to_reg = state == WB && op == OP_LW;
        // Retire points: jump in DECODE, store once memory accepts it, any write-back
        ctrl.instr_done = jump || (state == MEM && op == OP_SW && mem_ready) || state == WB;
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control sequencer for the 8-bit four-register CPU datapath
//   Clk, Clear        clock and asynchronous active-low reset
//   Run, Step         free-run level and single-instruction start pulse (honoured only in IDLE)
//   Opcode            IR[7:6], sampled in DECODE
//   Mem_Ready         memory handshake for FETCH and MEM
//   RegDst..PC_Src    datapath select and enable lines
//   Instr_Done        one-cycle retire pulse
//   State             current state encoding for debug/LEDs
//   Instr_Count       retired-instruction counter, wraps modulo 2^COUNT_W
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int COUNT_W = COUNT_W_DEFAULT
) (
    input  logic               Clk,
    input  logic               Clear,
    input  logic               Run,
    input  logic               Step,
    input  logic [1:0]         Opcode,
    input  logic               Mem_Ready,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrc,
    output logic               MemtoReg,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IorD,
    output logic               IR_Write,
    output logic               PC_Write,
    output logic               PC_Src,
    output logic               Instr_Done,
    output logic [2:0]         State,
    output logic [COUNT_W-1:0] Instr_Count
);

    state_t             state;
    state_t             state_nxt;
    logic   [1:0]       op_q;
    logic   [1:0]       op;
    logic [COUNT_W-1:0] count;
    ctrl_t              ctrl;

    // op_q only becomes valid after DECODE, so DECODE itself looks at the live opcode
    assign op = state == DECODE ? Opcode : op_q;

    always_ff @(posedge Clk or negedge Clear) begin
        if (!Clear) begin
            state <= IDLE;
            op_q  <= OP_ADD;
            count <= '0;
        end else begin
            state <= state_nxt;
            op_q  <= state == DECODE ? Opcode : op_q;
            count <= ctrl.instr_done ? count + COUNT_W'(1) : count;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = (Run || Step) ? FETCH : IDLE;
            FETCH:   state_nxt = Mem_Ready ? DECODE : FETCH;
            DECODE:  state_nxt = EXEC;
            EXEC:    state_nxt = op_q == OP_ADD ? WB : MEM;
            MEM:     state_nxt = Mem_Ready ? WB : MEM;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Retiring overrides the per-state choice; Run alone picks the next instruction
        if (ctrl.instr_done)
            state_nxt = Run ? FETCH : IDLE;
    end

    ctrl_decode u_decode (
        .state     (state),
        .op        (op),
        .mem_ready (Mem_Ready),
        .ctrl      (ctrl)
    );

    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrc      = ctrl.alu_src;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IorD        = ctrl.iord;
    assign IR_Write    = ctrl.ir_write;
    assign PC_Write    = ctrl.pc_write;
    assign PC_Src      = ctrl.pc_src;
    assign Instr_Done  = ctrl.instr_done;
    assign State       = state;
    assign Instr_Count = count;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic       Clk = 1'b0;
    logic       Clear = 1'b0;
    logic       Run = 1'b0;
    logic       Step = 1'b0;
    logic [1:0] Opcode = 2'd0;
    logic       Mem_Ready = 1'b0;
    logic       RegDst, RegWrite, ALUSrc, MemtoReg, MemRead, MemWrite, IorD;
    logic       IR_Write, PC_Write, PC_Src, Instr_Done;
    logic [2:0] State;
    logic [7:0] Instr_Count;
    logic [10:0] obs;

    multicycle_ctrl #(.COUNT_W(8)) dut (
        .Clk(Clk), .Clear(Clear), .Run(Run), .Step(Step), .Opcode(Opcode),
        .Mem_Ready(Mem_Ready), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
        .MemtoReg(MemtoReg), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
        .IR_Write(IR_Write), .PC_Write(PC_Write), .PC_Src(PC_Src),
        .Instr_Done(Instr_Done), .State(State), .Instr_Count(Instr_Count)
    );

    always #5 Clk = ~Clk;

    assign obs = {RegDst, RegWrite, ALUSrc, MemtoReg, MemRead, MemWrite, IorD,
                  IR_Write, PC_Write, PC_Src, Instr_Done};

    // Expected control words per phase, bit order as in obs
    localparam logic [10:0] O_IDLE = 11'h000;
    localparam logic [10:0] O_FW   = 11'h040;
    localparam logic [10:0] O_FG   = 11'h04C;
    localparam logic [10:0] O_DJ   = 11'h007;
    localparam logic [10:0] O_EX   = 11'h100;
    localparam logic [10:0] O_ML   = 11'h050;
    localparam logic [10:0] O_MSW  = 11'h030;
    localparam logic [10:0] O_MSD  = 11'h031;
    localparam logic [10:0] O_WA   = 11'h601;
    localparam logic [10:0] O_WL   = 11'h281;

    typedef struct packed {
        logic        run;
        logic        step;
        logic        mr;
        logic [1:0]  op;
        logic [2:0]  st;
        logic [10:0] out;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    int          done_seen = 0;
    int          ir_seen = 0;
    logic [7:0]  cnt_exp = 8'd0;
    vec_t        q[$];
    vec_t        tbl[17];

    function automatic vec_t mk(logic r, logic s, logic m, logic [1:0] o, logic [2:0] t, logic [10:0] e);
        vec_t v;
        v.run = r; v.step = s; v.mr = m; v.op = o; v.st = t; v.out = e;
        return v;
    endfunction

    task automatic chk(string nm, int idx, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s #%0d: got %0h expected %0h", nm, idx, got, exp);
        end
    endtask

    task automatic step_rec(vec_t v, int idx);
        @(posedge Clk);
        #1;
        Run = v.run;
        Step = v.step;
        Opcode = v.op;
        Mem_Ready = (v.st == 3'd1 || v.st == 3'd4) ? v.mr : 1'($urandom_range(0, 1));
        @(negedge Clk);
        chk("state", idx, 32'(State), 32'(v.st));
        chk("ctrl", idx, 32'(obs), 32'(v.out));
        chk("count", idx, 32'(Instr_Count), 32'(cnt_exp));
        done_seen += int'(Instr_Done);
        ir_seen += int'(IR_Write);
        if (v.out[0]) cnt_exp++;
    endtask

    task automatic idle(logic r, logic s);
        q.push_back(mk(r, s, 1'b0, 2'd0, 3'd0, O_IDLE));
    endtask

    // Expected trace of one instruction with fw/mw not-ready cycles in FETCH/MEM, Run held high
    task automatic gen(logic [1:0] op, int fw, int mw);
        repeat (fw) q.push_back(mk(1'b1, 1'b0, 1'b0, op, 3'd1, O_FW));
        q.push_back(mk(1'b1, 1'b0, 1'b1, op, 3'd1, O_FG));
        if (op == 2'd3) begin
            q.push_back(mk(1'b1, 1'b0, 1'b1, op, 3'd2, O_DJ));
            return;
        end
        q.push_back(mk(1'b1, 1'b0, 1'b1, op, 3'd2, O_IDLE));
        q.push_back(mk(1'b1, 1'b0, 1'b1, op, 3'd3, op == 2'd0 ? O_IDLE : O_EX));
        if (op != 2'd0) begin
            repeat (mw) q.push_back(mk(1'b1, 1'b0, 1'b0, op, 3'd4, op == 2'd1 ? O_ML : O_MSW));
            q.push_back(mk(1'b1, 1'b0, 1'b1, op, 3'd4, op == 2'd1 ? O_ML : O_MSD));
        end
        if (op != 2'd2) q.push_back(mk(1'b1, 1'b0, 1'b1, op, 3'd5, op == 2'd0 ? O_WA : O_WL));
    endtask

    task automatic apply(int n);
        for (int i = 0; i < n; i++) step_rec(q[i], i);
        q.delete();
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_state", 0, 32'(State), 32'd0);
        chk("rst_ctrl", 0, 32'(obs), 32'd0);
        chk("rst_count", 0, 32'(Instr_Count), 32'd0);
        @(negedge Clk);
        Clear = 1'b1;

        // Directed program add, lw, sw, j in free run
        tbl = '{
            mk(1'b1, 1'b0, 1'b0, 2'd0, 3'd0, O_IDLE),
            mk(1'b1, 1'b0, 1'b1, 2'd0, 3'd1, O_FG),
            mk(1'b1, 1'b0, 1'b1, 2'd0, 3'd2, O_IDLE),
            mk(1'b1, 1'b0, 1'b1, 2'd0, 3'd3, O_IDLE),
            mk(1'b1, 1'b0, 1'b1, 2'd0, 3'd5, O_WA),
            mk(1'b1, 1'b0, 1'b1, 2'd1, 3'd1, O_FG),
            mk(1'b1, 1'b0, 1'b1, 2'd1, 3'd2, O_IDLE),
            mk(1'b1, 1'b0, 1'b1, 2'd1, 3'd3, O_EX),
            mk(1'b1, 1'b0, 1'b1, 2'd1, 3'd4, O_ML),
            mk(1'b1, 1'b0, 1'b1, 2'd1, 3'd5, O_WL),
            mk(1'b1, 1'b0, 1'b1, 2'd2, 3'd1, O_FG),
            mk(1'b1, 1'b0, 1'b1, 2'd2, 3'd2, O_IDLE),
            mk(1'b1, 1'b0, 1'b1, 2'd2, 3'd3, O_EX),
            mk(1'b1, 1'b0, 1'b1, 2'd2, 3'd4, O_MSD),
            mk(1'b1, 1'b0, 1'b1, 2'd3, 3'd1, O_FG),
            mk(1'b0, 1'b0, 1'b1, 2'd3, 3'd2, O_DJ),
            mk(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, O_IDLE)
        };
        done_seen = 0;
        for (int i = 0; i < 17; i++) step_rec(tbl[i], 100 + i);
        chk("prog_count", 0, 32'(Instr_Count), 32'd4);
        chk("prog_done", 0, 32'(done_seen), 32'd4);

        // lw with 3 FETCH waits and 2 MEM waits, then stop
        ir_seen = 0;
        idle(1'b1, 1'b0);
        gen(2'd1, 3, 2);
        q[q.size() - 1].run = 1'b0;
        idle(1'b0, 1'b0);
        chk("lw_len", 0, 32'(q.size()), 32'd12);
        apply(q.size());
        chk("lw_irw", 0, 32'(ir_seen), 32'd1);

        // Single step of an add; extra Step pulses mid-instruction ignored
        done_seen = 0;
        idle(1'b0, 1'b1);
        gen(2'd0, 0, 0);
        for (int i = 1; i < q.size(); i++) q[i].run = 1'b0;
        q[3].step = 1'b1;
        q[4].step = 1'b1;
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        apply(q.size());
        chk("step_done", 0, 32'(done_seen), 32'd1);

        // Run drops during EXEC of a lw
        idle(1'b1, 1'b0);
        gen(2'd1, 0, 1);
        for (int i = 3; i < q.size(); i++) q[i].run = 1'b0;
        repeat (3) idle(1'b0, 1'b0);
        apply(q.size());

        // Random back-to-back program with random memory latency
        idle(1'b1, 1'b0);
        for (int n = 0; n < 40; n++)
            gen(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        q[q.size() - 1].run = 1'b0;
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        apply(q.size());

        // Asynchronous reset in MEM of a lw waiting on memory
        idle(1'b1, 1'b0);
        gen(2'd1, 0, 5);
        apply(6);
        #2;
        Clear = 1'b0;
        #1;
        chk("arst_memread", 0, 32'(MemRead), 32'd0);
        chk("arst_iord", 0, 32'(IorD), 32'd0);
        chk("arst_state", 0, 32'(State), 32'd0);
        chk("arst_count", 0, 32'(Instr_Count), 32'd0);
        Run = 1'b0;
        Mem_Ready = 1'b0;
        cnt_exp = 8'd0;
        @(posedge Clk);
        @(negedge Clk);
        Clear = 1'b1;

        // 256 jumps: counter passes 255 -> 0 with Instr_Done still pulsing
        done_seen = 0;
        idle(1'b1, 1'b0);
        repeat (256) gen(2'd3, int'($urandom_range(0, 1)), 0);
        q[q.size() - 1].run = 1'b0;
        idle(1'b0, 1'b0);
        apply(q.size());
        chk("wrap_done", 0, 32'(done_seen), 32'd256);
        chk("wrap_count", 0, 32'(Instr_Count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
